// File: rtl/bank_biu_pkg.sv
// Shared widths, burst length and read-path state encoding for the bank-side
// linefill bus interface unit.
package bank_biu_pkg;
  localparam int LF_ID_W = 6;
  localparam int NUM_IDS = 1 << LF_ID_W;
  localparam int BEAT_W  = 128;
  localparam int LINE_W  = 256;
  localparam logic [7:0] ARLEN_LF = 8'd1;

  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    OUT   = 2'd2
  } r_state_e;
endpackage

// File: rtl/bank_biu_inflight_tracker.sv
// In-flight linefill tracking: one pending bit per {set,way} id plus an
// outstanding counter saturating at MAX_OS.
module bank_biu_inflight_tracker
  import bank_biu_pkg::*;
#(
  parameter int MAX_OS = 8,
  localparam int CNT_W = $clog2(MAX_OS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alloc_valid_i,
  input  logic [LF_ID_W-1:0] alloc_id_i,
  input  logic               rel_valid_i,
  input  logic [LF_ID_W-1:0] rel_id_i,
  output logic [NUM_IDS-1:0] pending_o,
  output logic               full_o,
  output logic [CNT_W-1:0]   os_cnt_o
);
  logic [NUM_IDS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   os_cnt_q, os_cnt_d;
  logic               inc, dec;

  // Alloc and release always target different ids, so bit updates are independent.
  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_pend
    assign pending_d[gi] = (pending_q[gi] & ~(rel_valid_i & (rel_id_i == LF_ID_W'(gi))))
                         | (alloc_valid_i & (alloc_id_i == LF_ID_W'(gi)));
  end

  assign full_o = (os_cnt_q == CNT_W'(MAX_OS));
  assign inc    = alloc_valid_i & ~full_o;
  assign dec    = rel_valid_i & (os_cnt_q != '0);

  always_comb begin
    os_cnt_d = os_cnt_q;
    if (inc && !dec)      os_cnt_d = os_cnt_q + CNT_W'(1);
    else if (dec && !inc) os_cnt_d = os_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      os_cnt_q  <= '0;
    end else begin
      pending_q <= pending_d;
      os_cnt_q  <= os_cnt_d;
    end
  end

  assign pending_o = pending_q;
  assign os_cnt_o  = os_cnt_q;
endmodule

// File: rtl/bank_biu_linefill_ctrl.sv
// Linefill BIU: issues 2-beat read bursts and returns assembled 256-bit lines.
// Define BANK_BIU_LF_CHECK_EN to enable the sticky R-channel protocol checker.
module bank_biu_linefill_ctrl
  import bank_biu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MAX_OS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [LF_ID_W-1:0] req_id_i,
  output logic               mem_arvalid_o,
  input  logic               mem_arready_i,
  output logic [ADDR_W-1:0]  mem_araddr_o,
  output logic [LF_ID_W-1:0] mem_arid_o,
  output logic [7:0]         mem_arlen_o,
  input  logic               mem_rvalid_i,
  output logic               mem_rready_o,
  input  logic [BEAT_W-1:0]  mem_rdata_i,
  input  logic [LF_ID_W-1:0] mem_rid_i,
  input  logic               mem_rlast_i,
  output logic               biu_isu_rvalid_o,
  input  logic               biu_isu_rready_i,
  output logic [LINE_W-1:0]  biu_isu_rdata_o,
  output logic [LF_ID_W-1:0] biu_isu_rid_o,
  output logic               lf_err_o
);
  localparam int CNT_W = $clog2(MAX_OS + 1);

  logic               ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0]  ar_addr_q, ar_addr_d;
  logic [LF_ID_W-1:0] ar_id_q, ar_id_d;
  r_state_e           r_state_q;
  logic               rready_q, isu_rvalid_q;
  logic [LINE_W-1:0]  line_q;
  logic [LF_ID_W-1:0] rid_q;
  logic [NUM_IDS-1:0] pending;
  logic               full;
  logic [CNT_W-1:0]   os_cnt;
  logic               accept, beat_hs, rel_fire;

  // Holding reset keeps the request side closed along with every other output.
  assign req_ready_o = (~ar_valid_q | mem_arready_i) & ~full & ~pending[req_id_i] & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign beat_hs     = mem_rvalid_i & rready_q;
  assign rel_fire    = (r_state_q == OUT) & biu_isu_rready_i;

  bank_biu_inflight_tracker #(.MAX_OS(MAX_OS)) u_tracker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_valid_i (accept),
    .alloc_id_i    (req_id_i),
    .rel_valid_i   (rel_fire),
    .rel_id_i      (rid_q),
    .pending_o     (pending),
    .full_o        (full),
    .os_cnt_o      (os_cnt)
  );

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    if (ar_valid_q && mem_arready_i) ar_valid_d = 1'b0;
    if (accept) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = req_addr_i;
      ar_id_d    = req_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
    end
  end

  // rready comes up one cycle after reset release, then drops only while a line waits in OUT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q    <= BEAT0;
      rready_q     <= 1'b0;
      isu_rvalid_q <= 1'b0;
      line_q       <= '0;
      rid_q        <= '0;
    end else begin
      case (r_state_q)
        BEAT0: begin
          rready_q <= 1'b1;
          if (beat_hs) begin
            line_q[BEAT_W-1:0] <= mem_rdata_i;
            rid_q              <= mem_rid_i;
            r_state_q          <= BEAT1;
          end
        end
        BEAT1: begin
          if (beat_hs) begin
            line_q[LINE_W-1:BEAT_W] <= mem_rdata_i;
            rready_q                <= 1'b0;
            isu_rvalid_q            <= 1'b1;
            r_state_q               <= OUT;
          end
        end
        OUT: begin
          if (biu_isu_rready_i) begin
            rready_q     <= 1'b1;
            isu_rvalid_q <= 1'b0;
            r_state_q    <= BEAT0;
          end
        end
        default: r_state_q <= BEAT0;
      endcase
    end
  end

`ifdef BANK_BIU_LF_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (beat_hs && (r_state_q == BEAT0) && mem_rlast_i) err_d = 1'b1;
    if (beat_hs && (r_state_q == BEAT1) && (!mem_rlast_i || (mem_rid_i != rid_q))) err_d = 1'b1;
    if (beat_hs && !pending[mem_rid_i]) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign lf_err_o = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = mem_rlast_i;
  assign lf_err_o     = 1'b0;
`endif

  assign mem_arvalid_o    = ar_valid_q;
  assign mem_araddr_o     = ar_addr_q;
  assign mem_arid_o       = ar_id_q;
  assign mem_arlen_o      = ARLEN_LF;
  assign mem_rready_o     = rready_q;
  assign biu_isu_rvalid_o = isu_rvalid_q;
  assign biu_isu_rdata_o  = line_q;
  assign biu_isu_rid_o    = rid_q;
endmodule
